// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a 32 x 8-bit register file to an SPI master,
// with a local read/write port, write-notify strobe and W1C interrupt flags.
module spi_reg_responder #(
  parameter int IRQ_REG     = 25,
  parameter int IEN_REG     = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       spi_SCLK,
  input  logic       spi_MOSI,
  input  logic       spi_SS_n,
  output logic       spi_MISO,
  output logic       spi_MISO_oe,
  input  logic [4:0] loc_addr,
  input  logic       loc_we,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  input  logic [7:0] loc_irq_set,
  output logic       spi_wr_strobe,
  output logic [4:0] spi_wr_addr,
  output logic [7:0] spi_wr_data,
  output logic       busy,
  output logic       irq
);

  localparam logic [4:0] IRQ_A = 5'(IRQ_REG);
  localparam logic [4:0] IEN_A = 5'(IEN_REG);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_prev, ss_prev;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift;
  logic [4:0]             addr;
  logic [7:0]             regs [32];

  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_rise, sclk_fall, ss_fall;
  logic       byte_done, spi_we;
  logic [7:0] rx_byte, irq_next;

  // Select chain resets to "selected" so a master still holding SS_n low
  // after reset cannot fake a falling edge; it must deselect first.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b0;
    end else begin
      sclk_sync[0] <= spi_SCLK;
      mosi_sync[0] <= spi_MOSI;
      ss_sync[0]   <= spi_SS_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
      end
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ~ss_s & ss_prev;
  assign rx_byte   = {rx_shift[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !ss_s;
  assign spi_we    = (state == WR) && byte_done;
  assign spi_MISO  = tx_shift[7];

  // Flag register: local write overwrites unless SPI hits it too, SPI clears
  // written ones, and set pulses are applied last so they always win.
  always_comb begin
    irq_next = regs[IRQ_A];
    if (loc_we && loc_addr == IRQ_A)
      irq_next = loc_wdata;
    if (spi_we && addr == IRQ_A)
      irq_next = regs[IRQ_A] & ~rx_byte;
    irq_next = irq_next | loc_irq_set;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (5'(i) == IRQ_A)
          regs[i] <= irq_next;
        else if (spi_we && addr == 5'(i))
          regs[i] <= rx_byte;
        else if (loc_we && loc_addr == 5'(i))
          regs[i] <= loc_wdata;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      loc_rdata     <= '0;
      irq           <= 1'b0;
      spi_wr_strobe <= 1'b0;
      spi_wr_addr   <= '0;
      spi_wr_data   <= '0;
    end else begin
      loc_rdata     <= regs[loc_addr];
      irq           <= |(regs[IRQ_A] & regs[IEN_A]);
      spi_wr_strobe <= spi_we;
      if (spi_we) begin
        spi_wr_addr <= addr;
        spi_wr_data <= rx_byte;
      end
    end
  end

  // Deselect always wins; a partially shifted byte is simply dropped.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      addr        <= '0;
      busy        <= 1'b0;
      spi_MISO_oe <= 1'b0;
    end else if (ss_s) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      busy        <= 1'b0;
      spi_MISO_oe <= 1'b0;
    end else if (state == IDLE) begin
      if (ss_fall) begin
        state       <= CMD;
        tx_shift    <= regs[IRQ_A];
        bit_cnt     <= '0;
        busy        <= 1'b1;
        spi_MISO_oe <= 1'b1;
      end
    end else if (sclk_rise) begin
      rx_shift <= rx_byte;
      bit_cnt  <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        case (state)
          CMD: begin
            addr <= rx_byte[7:3];
            if (rx_byte[1]) begin
              state    <= WR;
              tx_shift <= '0;
            end else begin
              state    <= RD;
              tx_shift <= regs[rx_byte[7:3]];
            end
          end
          WR: addr <= addr + 5'd1;
          RD: begin
            addr     <= addr + 5'd1;
            tx_shift <= regs[addr + 5'd1];
          end
          default: ;
        endcase
      end
    end else if (sclk_fall && bit_cnt != 3'd0) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI-mode-0 peripheral (responder) serving a 32 x 8-bit register file to the SoC's SPI master.
- Command framing follows the USB-host controller convention: the command byte carries reg[4:0] in bits 7:3 and DIR in bit 1 (1 = write); a status byte is returned during the command byte.
- Used as an on-FPGA stand-in for the USB controller during bring-up, and as a generic SPI-mapped control/status endpoint.
- The local side gets a read/write port, a write-notify strobe and an interrupt output.

Parameters:
- IRQ_REG, 25, index of interrupt-flag register (returned as status byte; write-1-to-clear from SPI).
- IEN_REG, 26, index of interrupt-enable register.
- SYNC_STAGES, 2, synchronizer depth on spi_SCLK/spi_MOSI/spi_SS_n.

Ports:
- clk_clk  in  1  system clock; must be >= 8x SCLK frequency.
- reset_reset  in  1  synchronous, active-high reset.
- spi_SCLK  in  1  SPI clock from master (idle low).
- spi_MOSI  in  1  master-out data.
- spi_SS_n  in  1  active-low select.
- spi_MISO  out  1  responder-out data.
- spi_MISO_oe  out  1  MISO output enable = synchronized select active.
- loc_addr  in  5  local register address.
- loc_we  in  1  local write enable.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  local read data, registered.
- loc_irq_set  in  8  per-bit set pulses into reg[IRQ_REG].
- spi_wr_strobe  out  1  one-cycle pulse per SPI-completed write byte.
- spi_wr_addr  out  5  address of that write.
- spi_wr_data  out  8  data of that write.
- busy  out  1  high while a transaction is in progress (state != IDLE).
- irq  out  1  |(reg[IRQ_REG] & reg[IEN_REG]), registered.

Behaviour:
- Synchronous, active-high reset (reset_reset sampled on clk_clk):
  - register file cleared to 0;
  - state = IDLE; bit_cnt = 0;
  - spi_MISO = 0, spi_MISO_oe = 0, loc_rdata = 0, spi_wr_strobe = 0, spi_wr_addr = 0, spi_wr_data = 0, busy = 0, irq = 0.
  - Reset mid-transfer aborts the transfer with no write; the master's remaining clocks are ignored until the next SS_n falling edge.
- Synchronization:
  - SCLK, MOSI and SS_n each pass through SYNC_STAGES flops.
  - Rising and falling SCLK edges are detected from the last two synchronized samples.
  - All SPI actions occur on the detected-edge cycle.
- SPI mode 0, MSB first:
  - MOSI is sampled on SCLK rise.
  - MISO is updated on SCLK fall.
  - bit_cnt counts rises modulo 8.
  - MISO = tx_shift[7]. tx_shift shifts left on a fall only when bit_cnt != 0, which suppresses the shift right after a byte load.
- FSM IDLE -> CMD -> {WR, RD}:
  - IDLE: on synchronized SS_n falling: load tx_shift = reg[IRQ_REG] (status byte), bit_cnt = 0, go to CMD.
  - CMD: on the 8th rise: addr = cmd[7:3]. Go to WR if cmd[1] = 1, else RD. In RD, immediately load tx_shift = reg[addr]; in WR, load tx_shift = 0.
  - WR: on each 8th rise: write rx byte to reg[addr]; pulse spi_wr_strobe the next cycle with the pre-increment address and the data; addr = addr + 1 mod 32 (31 wraps to 0).
  - RD: on each 8th rise: addr = addr + 1 mod 32, then load tx_shift = reg[new addr]. The byte returned is sampled at that cycle (read-after-write is coherent).
  - Any state: synchronized SS_n high -> IDLE. A partial byte is discarded with no write and no strobe; spi_MISO_oe drops in the same cycle.
- IRQ_REG semantics:
  - An SPI write clears the bits written as 1 (W1C).
  - loc_irq_set ORs bits in.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - A local write to IRQ_REG is a plain overwrite.
- Collisions: if an SPI write and loc_we target the same address in the same cycle, the SPI write wins; the local write is dropped. The IRQ_REG W1C and set-precedence rules still apply.
- Local read: loc_rdata = reg[loc_addr] registered, 1-cycle latency; it reflects writes completed in the prior cycle.
- irq: registered from the register state, 1 cycle after the flag or enable changes.

Test Plan:
- Write burst: SS low, cmd 0x2A (reg 5, write), data 0x11, 0x22, SS high -> reg5 = 0x11, reg6 = 0x22; two spi_wr_strobe pulses with (5, 0x11) and (6, 0x22); busy low after SS high.
- Read with wrap: preload reg31 = 0xA5, reg0 = 0x3C via local port; cmd 0xF8 (reg 31, read), 16 clocks -> MISO bytes 0xA5, 0x3C; status byte during cmd = reg25.
- IRQ path: reg26 = 0x01 locally, loc_irq_set = 0x01 pulse -> irq = 1 one cycle after reg25 updates; SPI write cmd 0xCA, data 0x01 -> reg25 = 0, irq = 0; same-cycle set + clear -> bit stays 1.
- Abort: cmd 0x12 (reg 2, write) then 5 data bits then SS high -> reg2 unchanged, no strobe; next transaction decodes normally.
- Collision: SPI write byte completes on reg 7 with 0x55 in the same cycle as loc_we reg 7 = 0xAA -> reg7 = 0x55.
- Reset mid-read (after 3 data bits) -> all outputs 0, state IDLE, register file 0; a fresh transaction after reset works.
